// File: rtl/sd_dac_pkg.sv
// Shared constants and helpers for the sigma-delta audio mixer.
package sd_dac_pkg;

  localparam int unsigned VOL_W     = 4;
  localparam int unsigned PAN_W     = 2;
  localparam int unsigned PAN_L_BIT = 0;
  localparam int unsigned PAN_R_BIT = 1;

  // Width of the mixed sum: one extra bit per doubling of the channel count.
  function automatic int unsigned mix_width(input int unsigned c_bits,
                                            input int unsigned channels);
    return (channels > 1) ? c_bits + $clog2(channels) : c_bits;
  endfunction

endpackage

// File: rtl/sd_mod.sv
// Single-side pulse-density modulator.
// Define SD_SECOND_ORDER_EN for a second-order error-feedback loop; otherwise first order.
module sd_mod #(
  parameter int unsigned MIX_W = 9
) (
  input  logic             clk_i,
  input  logic             res_n_i,
  input  logic [MIX_W-1:0] mix_i,
  output logic             dac_o
);

`ifdef SD_SECOND_ORDER_EN
  localparam int unsigned INT_W = MIX_W + 3;
  // Full-scale feedback, 2^MIX_W.
  localparam logic signed [INT_W-1:0] FB_ONE = {3'b001, {MIX_W{1'b0}}};

  logic signed [INT_W-1:0] int1_q, int2_q;
  logic signed [INT_W-1:0] int1_d, int2_d, x, fb;
  logic                    q_bit;

  // Quantise integrator 2, feed back the bit, advance both integrators.
  always_comb begin
    x      = signed'({3'b000, mix_i});
    q_bit  = ~int2_q[INT_W-1];
    fb     = q_bit ? FB_ONE : '0;
    int1_d = int1_q + x - fb;
    int2_d = int2_q + int1_d - fb;
  end

  // Integrator state and registered output bit.
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      int1_q <= '0;
      int2_q <= '0;
      dac_o  <= 1'b0;
    end else begin
      int1_q <= int1_d;
      int2_q <= int2_d;
      dac_o  <= q_bit;
    end
  end
`else
  logic [MIX_W:0] sd_q;

  // First-order accumulator; the carry out is the pulse.
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      sd_q  <= '0;
      dac_o <= 1'b0;
    end else begin
      sd_q  <= {1'b0, sd_q[MIX_W-1:0]} + {1'b0, mix_i};
      dac_o <= sd_q[MIX_W];
    end
  end
`endif

endmodule

// File: rtl/sd_dac_mixer.sv
// Multi-channel sigma-delta audio mixer: per-channel volume and pan, one shared
// multiplier scanned round-robin, stereo pulse-density outputs.
// Modulator order selected by SD_SECOND_ORDER_EN (see sd_mod).
module sd_dac_mixer
  import sd_dac_pkg::*;
#(
  parameter int unsigned C_BITS   = 8,
  parameter int unsigned CHANNELS = 2
) (
  input  logic                       clk_i,
  input  logic                       res_n_i,
  input  logic [CHANNELS*C_BITS-1:0] sample_i,
  input  logic [CHANNELS-1:0]        sample_we_i,
  input  logic [CHANNELS*VOL_W-1:0]  vol_i,
  input  logic [CHANNELS*PAN_W-1:0]  pan_i,
  input  logic                       mute_i,
  output logic                       frame_o,
  output logic                       dac_l_o,
  output logic                       dac_r_o
);

  localparam int unsigned MIX_W = mix_width(C_BITS, CHANNELS);
  localparam int unsigned IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);

  logic [C_BITS-1:0] shadow_q [CHANNELS];
  logic [IDX_W-1:0]  ch_idx_q;
  logic [MIX_W-1:0]  acc_l_q, acc_r_q;
  logic [MIX_W-1:0]  mix_l_q, mix_r_q;

  logic [C_BITS-1:0] cur_sample;
  logic [VOL_W-1:0]  cur_vol;
  logic [PAN_W-1:0]  cur_pan;
  logic [C_BITS-1:0] term;
  logic [MIX_W-1:0]  sum_l, sum_r;
  logic              last_ch;

  // Shadow sample registers, loaded independently of the scanner.
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      for (int n = 0; n < CHANNELS; n++) shadow_q[n] <= '0;
    end else begin
      for (int n = 0; n < CHANNELS; n++) begin
        if (sample_we_i[n]) shadow_q[n] <= sample_i[n*C_BITS +: C_BITS];
      end
    end
  end

  // Scale the currently scanned channel and route it to each side.
  always_comb begin
    cur_sample = shadow_q[ch_idx_q];
    cur_vol    = vol_i[ch_idx_q*VOL_W +: VOL_W];
    cur_pan    = pan_i[ch_idx_q*PAN_W +: PAN_W];
    // gain = vol/16, keep the integer part only
    term       = C_BITS'(({VOL_W'(0), cur_sample} * {C_BITS'(0), cur_vol}) >> VOL_W);
    sum_l      = acc_l_q + (cur_pan[PAN_L_BIT] ? MIX_W'(term) : '0);
    sum_r      = acc_r_q + (cur_pan[PAN_R_BIT] ? MIX_W'(term) : '0);
    last_ch    = (ch_idx_q == LAST_IDX);
  end

  // Scanner, accumulators and frame-end mix registers.
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      ch_idx_q <= '0;
      acc_l_q  <= '0;
      acc_r_q  <= '0;
      mix_l_q  <= '0;
      mix_r_q  <= '0;
      frame_o  <= 1'b0;
    end else begin
      frame_o <= last_ch;
      if (last_ch) begin
        ch_idx_q <= '0;
        acc_l_q  <= '0;
        acc_r_q  <= '0;
        mix_l_q  <= mute_i ? '0 : sum_l;
        mix_r_q  <= mute_i ? '0 : sum_r;
      end else begin
        ch_idx_q <= ch_idx_q + 1'b1;
        acc_l_q  <= sum_l;
        acc_r_q  <= sum_r;
      end
    end
  end

  sd_mod #(
    .MIX_W (MIX_W)
  ) u_mod_l (
    .clk_i   (clk_i),
    .res_n_i (res_n_i),
    .mix_i   (mix_l_q),
    .dac_o   (dac_l_o)
  );

  sd_mod #(
    .MIX_W (MIX_W)
  ) u_mod_r (
    .clk_i   (clk_i),
    .res_n_i (res_n_i),
    .mix_i   (mix_r_q),
    .dac_o   (dac_r_o)
  );

endmodule

// File: tb/tb_sd_dac_mixer.sv
// Directed bench for sd_dac_mixer, CHANNELS=2, C_BITS=8.
module tb_sd_dac_mixer;

  localparam int unsigned C_BITS   = 8;
  localparam int unsigned CHANNELS = 2;

  logic        clk_i;
  logic        res_n_i;
  logic [15:0] sample_i;
  logic [1:0]  sample_we_i;
  logic [7:0]  vol_i;
  logic [3:0]  pan_i;
  logic        mute_i;
  logic        frame_o;
  logic        dac_l_o;
  logic        dac_r_o;

  int checks;
  int errors;

  sd_dac_mixer #(
    .C_BITS   (C_BITS),
    .CHANNELS (CHANNELS)
  ) dut (
    .clk_i       (clk_i),
    .res_n_i     (res_n_i),
    .sample_i    (sample_i),
    .sample_we_i (sample_we_i),
    .vol_i       (vol_i),
    .pan_i       (pan_i),
    .mute_i      (mute_i),
    .frame_o     (frame_o),
    .dac_l_o     (dac_l_o),
    .dac_r_o     (dac_r_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [7:0] s0, s1;
    logic [3:0] v0, v1;
    logic [1:0] p0, p1;
    int         exp_l, exp_r;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled at the falling edge.
  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic set_vec(input vec_t v);
    sample_i    = {v.s1, v.s0};
    vol_i       = {v.v1, v.v0};
    pan_i       = {v.p1, v.p0};
    sample_we_i = 2'b11;
    tick();
    sample_we_i = 2'b00;
  endtask

  task automatic wait_frame(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (frame_o) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check(name, int'(ok), 1);
  endtask

  task automatic count_ones(output int cl, output int cr);
    cl = 0;
    cr = 0;
    for (int i = 0; i < 512; i++) begin
      tick();
      cl += int'(dac_l_o);
      cr += int'(dac_r_o);
    end
  endtask

  initial begin
    int cl, cr;
    checks = 0;
    errors = 0;

    //         s0     s1     v0  v1  p0     p1     l    r
    vecs[0] = '{8'h80, 8'h00, 15, 0,  2'b01, 2'b00, 120, 0};
    vecs[1] = '{8'hFF, 8'hFF, 15, 15, 2'b11, 2'b11, 478, 478};
    vecs[2] = '{8'h40, 8'h20, 8,  4,  2'b01, 2'b10, 32,  8};
    vecs[3] = '{8'h10, 8'hF0, 1,  2,  2'b11, 2'b01, 31,  1};
    vecs[4] = '{8'hFF, 8'h01, 15, 15, 2'b10, 2'b10, 0,   239};
    vecs[5] = '{8'h03, 8'h07, 15, 15, 2'b11, 2'b11, 8,   8};
    vecs[6] = '{8'hAA, 8'h55, 15, 15, 2'b00, 2'b00, 0,   0};

    // Reset held with random inputs.
    res_n_i     = 1'b0;
    mute_i      = 1'b0;
    sample_i    = 16'($urandom);
    sample_we_i = 2'($urandom);
    vol_i       = 8'($urandom);
    pan_i       = 4'($urandom);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("reset_dac_l", int'(dac_l_o), 0);
      check("reset_dac_r", int'(dac_r_o), 0);
      check("reset_frame", int'(frame_o), 0);
      sample_i    = 16'($urandom);
      sample_we_i = 2'($urandom);
    end
    check("reset_mix_l", int'(dut.mix_l_q), 0);

    // Release: first frame pulse exactly CHANNELS cycles later.
    sample_we_i = 2'b00;
    res_n_i     = 1'b1;
    tick();
    check("frame_after_1", int'(frame_o), 0);
    tick();
    check("frame_after_2", int'(frame_o), 1);
    tick();
    check("frame_after_3", int'(frame_o), 0);

    // Table of steady-state mixes.
    for (int i = 0; i < 7; i++) begin
      set_vec(vecs[i]);
      repeat (6) tick();
      check($sformatf("vec%0d_mix_l", i), int'(dut.mix_l_q), vecs[i].exp_l);
      check($sformatf("vec%0d_mix_r", i), int'(dut.mix_r_q), vecs[i].exp_r);
      if (i < 2) begin
        count_ones(cl, cr);
        check($sformatf("vec%0d_ones_l", i), cl, vecs[i].exp_l);
        check($sformatf("vec%0d_ones_r", i), cr, vecs[i].exp_r);
      end
    end

    // Write to ch0 in the cycle the scanner visits ch0.
    set_vec(vecs[0]);
    repeat (6) tick();
    wait_frame("sync_write");
    sample_i    = {8'h00, 8'h40};
    sample_we_i = 2'b01;
    tick();
    sample_we_i = 2'b00;
    tick();
    check("wr_frame", int'(frame_o), 1);
    check("wr_old_mix", int'(dut.mix_l_q), 120);
    tick();
    tick();
    check("wr_new_frame", int'(frame_o), 1);
    check("wr_new_mix", int'(dut.mix_l_q), 60);

    // Mute for one full frame, then release.
    set_vec(vecs[1]);
    repeat (6) tick();
    wait_frame("sync_mute");
    mute_i = 1'b1;
    tick();
    tick();
    check("mute_frame", int'(frame_o), 1);
    check("mute_mix_l", int'(dut.mix_l_q), 0);
    check("mute_mix_r", int'(dut.mix_r_q), 0);
    mute_i = 1'b0;
    tick();
    tick();
    check("unmute_mix_l", int'(dut.mix_l_q), 478);
    check("unmute_mix_r", int'(dut.mix_r_q), 478);

    // Reset mid-frame discards partial accumulation.
    tick();
    res_n_i = 1'b0;
    tick();
    check("rst2_mix_l", int'(dut.mix_l_q), 0);
    check("rst2_frame", int'(frame_o), 0);
    res_n_i = 1'b1;
    tick();
    check("rst2_frame_1", int'(frame_o), 0);
    tick();
    check("rst2_frame_2", int'(frame_o), 1);
    check("rst2_mix_after", int'(dut.mix_l_q), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
